fifo_glb_arbiter: RTL and testbench
===================================

FIFO_GLB_ARBITER -- requirements
Module: fifo_glb_arbiter

Interface
REQ-001 The block SHALL have parameter LANES, default 32, meaning the number of request lanes per class (ifmap, ipsum, opsum).
REQ-002 The block SHALL have parameter GLB_RD_LAT, default 1, range 1..4, meaning the GLB read latency in cycles from the enable cycle to the data-valid cycle.
REQ-003 The block SHALL have one clock domain and a synchronous, active-high reset; no other clock or reset SHALL exist.
REQ-004 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ifmap_read_req_matrix_i  in  LANES  per-lane ifmap read request.
- ifmap_glb_read_addr_matrix_i  in  LANES x 32  per-lane ifmap read address.
- ipsum_read_req_matrix_i  in  LANES  per-lane ipsum read request.
- ipsum_glb_read_addr_matrix_i  in  LANES x 32  per-lane ipsum read address.
- opsum_glb_write_req_matrix_i  in  LANES  per-lane opsum write request.
- opsum_glb_write_addr_matrix_i  in  LANES x 32  per-lane opsum write address.
- opsum_glb_write_web_matrix_i  in  LANES x 4  per-lane byte write enables.
- opsum_fifo_pop_data_matrix_i  in  LANES x 32  opsum FIFO head data (first-word fall-through).
- glb_read_data_i  in  32  GLB read data.
- glb_en_o  out  1  GLB access enable.
- glb_we_o  out  1  GLB write, 1=write.
- glb_bwe_o  out  4  GLB byte write enables.
- glb_addr_o  out  32  GLB address.
- glb_wdata_o  out  32  GLB write data.
- ifmap_permit_push_matrix_o  out  LANES  one-hot ifmap push permit.
- ipsum_permit_push_matrix_o  out  LANES  one-hot ipsum push permit.
- opsum_permit_pop_matrix_o  out  LANES  one-hot opsum pop permit.
- ifmap_glb_read_data_o  out  32  ifmap read data.
- ipsum_glb_read_data_o  out  32  ipsum read data.
- fifo_glb_busy_o  out  1  a transaction is in flight.

Function
REQ-005 The block SHALL have FSM states IDLE, RD_ISSUE, RD_WAIT, RD_RESP and WR_ISSUE, and SHALL allow only one transaction in flight at any time.
REQ-006 In IDLE, the block SHALL select a winner by class priority opsum > ipsum > ifmap, and round-robin within the class starting at that class's pointer.
REQ-007 The block SHALL keep each class pointer at 3 bits wider than needed for LANES, no wrap issue; after a grant, the pointer SHALL become (winner+1) mod LANES, and the other classes' pointers SHALL be unchanged.
REQ-008 On a read win, the block SHALL latch the lane, class and address, and go IDLE->RD_ISSUE.
REQ-009 In RD_ISSUE, the block SHALL assert glb_en_o=1 and glb_we_o=0 with glb_addr_o equal to the latched address, then go to RD_WAIT if GLB_RD_LAT>1, else to RD_RESP.
REQ-010 RD_WAIT SHALL last GLB_RD_LAT-1 cycles, counted by a down-counter, then go to RD_RESP.
REQ-011 In RD_RESP, for exactly 1 cycle, the block SHALL assert the winning lane's permit_push bit and drive glb_read_data_i combinationally onto that class's read_data output, then go to IDLE.
REQ-012 On an opsum win, the block SHALL assert opsum_permit_pop_matrix_o[winner] for 1 cycle in that same IDLE cycle, and SHALL register the lane's address, web and pop data.
REQ-013 From IDLE after an opsum win, the block SHALL go to WR_ISSUE.
REQ-014 In WR_ISSUE, the block SHALL assert glb_en_o=1 and glb_we_o=1 for 1 cycle, with glb_bwe_o, glb_addr_o and glb_wdata_o equal to the registered values, then go to IDLE.
REQ-015 The block SHALL assert fifo_glb_busy_o exactly when the state is not IDLE, and also in an IDLE cycle that grants an opsum write.
REQ-016 The block SHALL mask each lane's request for the cycle immediately after its permit cycle, so a request still held in that cycle is not granted again.
REQ-017 When no request is pending, IDLE SHALL hold, all outputs SHALL be 0, and the pointers SHALL not move.
REQ-018 When requests from several classes arrive in the same cycle, only the highest-priority class SHALL be served; lower classes SHALL wait, and their pointers SHALL not move.
REQ-019 A request that deasserts while its transaction is in flight SHALL not abort the transaction.
REQ-020 At most one bit across all permit outputs SHALL be 1 in any cycle.
REQ-021 When glb_en_o=0, glb_addr_o, glb_wdata_o and glb_bwe_o SHALL be 0, and the unused read_data output SHALL be 0.

Reset
REQ-022 While rst=1 at a clock edge, the next state SHALL be IDLE, all three pointers SHALL be 0, the wait counter and the mask SHALL be 0, and all outputs SHALL be 0.
REQ-023 Reset asserted mid-transaction SHALL drop the transaction with no permit issued; requesters re-request after reset.

Verification
REQ-024 Ifmap lane 5 req with addr 0x40, GLB_RD_LAT=1, GLB returns 0xDEADBEEF -> cycle 1: glb_en_o=1, glb_we_o=0, addr 0x40; cycle 2: ifmap_permit_push_matrix_o=1<<5 and ifmap_glb_read_data_o=0xDEADBEEF; busy high in cycles 1-2.
REQ-025 Opsum lane 3 req with addr 0x100, web 4'hF, data 0x12345678 -> cycle 0: opsum_permit_pop bit 3; cycle 1: glb_we_o=1, addr 0x100, wdata 0x12345678, bwe 4'hF.
REQ-026 Same-cycle requests ifmap lane 0, ipsum lane 0 and opsum lane 0, all held -> service order opsum, ipsum, ifmap; no two permits in the same cycle.
REQ-027 Ipsum lanes 2, 7 and 30 held continuously -> grants 2, 7, 30, 2 ... in order.
REQ-028 GLB_RD_LAT=3 read -> permit exactly 3 cycles after the RD_ISSUE cycle.
REQ-029 rst=1 during RD_WAIT -> next cycle: IDLE, all outputs 0, no permit.

Source files
------------

// File: rtl/fifo_glb_arbiter.sv
// Arbitrates ifmap/ipsum reads and opsum writes from LANES FIFO lanes onto one GLB port,
// one transaction at a time: fixed class priority, round-robin lanes within each class.
module fifo_glb_arbiter #(
    parameter int LANES      = 32,
    parameter int GLB_RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      ifmap_read_req_matrix_i,
    input  logic [LANES*32-1:0]   ifmap_glb_read_addr_matrix_i,
    input  logic [LANES-1:0]      ipsum_read_req_matrix_i,
    input  logic [LANES*32-1:0]   ipsum_glb_read_addr_matrix_i,
    input  logic [LANES-1:0]      opsum_glb_write_req_matrix_i,
    input  logic [LANES*32-1:0]   opsum_glb_write_addr_matrix_i,
    input  logic [LANES*4-1:0]    opsum_glb_write_web_matrix_i,
    input  logic [LANES*32-1:0]   opsum_fifo_pop_data_matrix_i,
    input  logic [31:0]           glb_read_data_i,
    output logic                  glb_en_o,
    output logic                  glb_we_o,
    output logic [3:0]            glb_bwe_o,
    output logic [31:0]           glb_addr_o,
    output logic [31:0]           glb_wdata_o,
    output logic [LANES-1:0]      ifmap_permit_push_matrix_o,
    output logic [LANES-1:0]      ipsum_permit_push_matrix_o,
    output logic [LANES-1:0]      opsum_permit_pop_matrix_o,
    output logic [31:0]           ifmap_glb_read_data_o,
    output logic [31:0]           ipsum_glb_read_data_o,
    output logic                  fifo_glb_busy_o
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = LANE_W + 3;

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_ISSUE} state_t;
    typedef enum logic {CLS_IFMAP, CLS_IPSUM} rd_cls_t;

    state_t             state_q, state_d;
    rd_cls_t            cls_q, cls_d;
    logic [PTR_W-1:0]   ptr_if_q, ptr_if_d, ptr_ip_q, ptr_ip_d, ptr_op_q, ptr_op_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]         bwe_q, bwe_d;
    logic [LANES-1:0]   mask_if_q, mask_if_d, mask_ip_q, mask_ip_d, mask_op_q, mask_op_d;

    logic               if_hit, ip_hit, op_hit;
    logic [LANE_W-1:0]  if_win, ip_win, op_win;

    // Returns {found, lane}: first requesting lane scanning upward from ptr with wrap.
    function automatic logic [LANE_W:0] rr_pick(input logic [LANES-1:0] req,
                                                input logic [PTR_W-1:0] ptr);
        logic              found;
        logic [LANE_W-1:0] win;
        logic [PTR_W-1:0]  idx;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < LANES; i++) begin
            idx = ptr + PTR_W'(i);
            if (idx >= PTR_W'(LANES)) idx = idx - PTR_W'(LANES);
            if (!found && req[idx[LANE_W-1:0]]) begin
                found = 1'b1;
                win   = idx[LANE_W-1:0];
            end
        end
        return {found, win};
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [LANE_W-1:0] win);
        if (PTR_W'(win) == PTR_W'(LANES - 1)) return '0;
        return PTR_W'(win) + PTR_W'(1);
    endfunction

    assign {if_hit, if_win} = rr_pick(ifmap_read_req_matrix_i & ~mask_if_q, ptr_if_q);
    assign {ip_hit, ip_win} = rr_pick(ipsum_read_req_matrix_i & ~mask_ip_q, ptr_ip_q);
    assign {op_hit, op_win} = rr_pick(opsum_glb_write_req_matrix_i & ~mask_op_q, ptr_op_q);

    // A lane that held a permit last cycle is blind for one cycle, so a stale request is not re-served.
    assign mask_if_d = ifmap_permit_push_matrix_o;
    assign mask_ip_d = ipsum_permit_push_matrix_o;
    assign mask_op_d = opsum_permit_pop_matrix_o;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d  = state_q;
        cls_d    = cls_q;
        ptr_if_d = ptr_if_q;
        ptr_ip_d = ptr_ip_q;
        ptr_op_d = ptr_op_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        bwe_d    = bwe_q;
        glb_en_o                   = 1'b0;
        glb_we_o                   = 1'b0;
        glb_bwe_o                  = '0;
        glb_addr_o                 = '0;
        glb_wdata_o                = '0;
        ifmap_permit_push_matrix_o = '0;
        ipsum_permit_push_matrix_o = '0;
        opsum_permit_pop_matrix_o  = '0;
        ifmap_glb_read_data_o      = '0;
        ipsum_glb_read_data_o      = '0;
        fifo_glb_busy_o            = 1'b0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (op_hit) begin
                        opsum_permit_pop_matrix_o[op_win] = 1'b1;
                        fifo_glb_busy_o = 1'b1;
                        addr_d   = opsum_glb_write_addr_matrix_i[32*int'(op_win) +: 32];
                        wdata_d  = opsum_fifo_pop_data_matrix_i[32*int'(op_win) +: 32];
                        bwe_d    = opsum_glb_write_web_matrix_i[4*int'(op_win) +: 4];
                        lane_d   = op_win;
                        ptr_op_d = next_ptr(op_win);
                        state_d  = WR_ISSUE;
                    end else if (ip_hit) begin
                        addr_d   = ipsum_glb_read_addr_matrix_i[32*int'(ip_win) +: 32];
                        lane_d   = ip_win;
                        cls_d    = CLS_IPSUM;
                        ptr_ip_d = next_ptr(ip_win);
                        state_d  = RD_ISSUE;
                    end else if (if_hit) begin
                        addr_d   = ifmap_glb_read_addr_matrix_i[32*int'(if_win) +: 32];
                        lane_d   = if_win;
                        cls_d    = CLS_IFMAP;
                        ptr_if_d = next_ptr(if_win);
                        state_d  = RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    glb_en_o        = 1'b1;
                    glb_addr_o      = addr_q;
                    fifo_glb_busy_o = 1'b1;
                    if (GLB_RD_LAT > 1) begin
                        cnt_d   = 3'(GLB_RD_LAT - 1);
                        state_d = RD_WAIT;
                    end else begin
                        state_d = RD_RESP;
                    end
                end
                RD_WAIT: begin
                    fifo_glb_busy_o = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = '0;
                        state_d = RD_RESP;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                RD_RESP: begin
                    fifo_glb_busy_o = 1'b1;
                    if (cls_q == CLS_IFMAP) begin
                        ifmap_permit_push_matrix_o[lane_q] = 1'b1;
                        ifmap_glb_read_data_o              = glb_read_data_i;
                    end else begin
                        ipsum_permit_push_matrix_o[lane_q] = 1'b1;
                        ipsum_glb_read_data_o              = glb_read_data_i;
                    end
                    state_d = IDLE;
                end
                WR_ISSUE: begin
                    glb_en_o        = 1'b1;
                    glb_we_o        = 1'b1;
                    glb_bwe_o       = bwe_q;
                    glb_addr_o      = addr_q;
                    glb_wdata_o     = wdata_q;
                    fifo_glb_busy_o = 1'b1;
                    state_d         = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cls_q     <= CLS_IFMAP;
            ptr_if_q  <= '0;
            ptr_ip_q  <= '0;
            ptr_op_q  <= '0;
            cnt_q     <= '0;
            lane_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bwe_q     <= '0;
            mask_if_q <= '0;
            mask_ip_q <= '0;
            mask_op_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            ptr_if_q  <= ptr_if_d;
            ptr_ip_q  <= ptr_ip_d;
            ptr_op_q  <= ptr_op_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            bwe_q     <= bwe_d;
            mask_if_q <= mask_if_d;
            mask_ip_q <= mask_ip_d;
            mask_op_q <= mask_op_d;
        end
    end

endmodule

// File: tb/tb_fifo_glb_arbiter.sv
// Bench for fifo_glb_arbiter: two instances (read latency 1 and 3) share directed stimulus and
// are compared every cycle against a transaction-timeline model, plus literal pinned values.
module tb_fifo_glb_arbiter;

    localparam int LANES = 32;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic                rst;
    logic [LANES-1:0]    if_req, ip_req, op_req;
    logic [LANES*32-1:0] if_addr, ip_addr, op_addr, op_data;
    logic [LANES*4-1:0]  op_web;
    logic [31:0]         glb_rdata;

    logic                en_o[2], we_o[2], busy_o[2];
    logic [3:0]          bwe_o[2];
    logic [31:0]         addr_o[2], wdata_o[2], ifd_o[2], ipd_o[2];
    logic [LANES-1:0]    ifp_o[2], ipp_o[2], opp_o[2];

    fifo_glb_arbiter #(.LANES(LANES), .GLB_RD_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst),
        .ifmap_read_req_matrix_i(if_req), .ifmap_glb_read_addr_matrix_i(if_addr),
        .ipsum_read_req_matrix_i(ip_req), .ipsum_glb_read_addr_matrix_i(ip_addr),
        .opsum_glb_write_req_matrix_i(op_req), .opsum_glb_write_addr_matrix_i(op_addr),
        .opsum_glb_write_web_matrix_i(op_web), .opsum_fifo_pop_data_matrix_i(op_data),
        .glb_read_data_i(glb_rdata),
        .glb_en_o(en_o[0]), .glb_we_o(we_o[0]), .glb_bwe_o(bwe_o[0]),
        .glb_addr_o(addr_o[0]), .glb_wdata_o(wdata_o[0]),
        .ifmap_permit_push_matrix_o(ifp_o[0]), .ipsum_permit_push_matrix_o(ipp_o[0]),
        .opsum_permit_pop_matrix_o(opp_o[0]),
        .ifmap_glb_read_data_o(ifd_o[0]), .ipsum_glb_read_data_o(ipd_o[0]),
        .fifo_glb_busy_o(busy_o[0])
    );

    fifo_glb_arbiter #(.LANES(LANES), .GLB_RD_LAT(3)) dut_lat3 (
        .clk(clk), .rst(rst),
        .ifmap_read_req_matrix_i(if_req), .ifmap_glb_read_addr_matrix_i(if_addr),
        .ipsum_read_req_matrix_i(ip_req), .ipsum_glb_read_addr_matrix_i(ip_addr),
        .opsum_glb_write_req_matrix_i(op_req), .opsum_glb_write_addr_matrix_i(op_addr),
        .opsum_glb_write_web_matrix_i(op_web), .opsum_fifo_pop_data_matrix_i(op_data),
        .glb_read_data_i(glb_rdata),
        .glb_en_o(en_o[1]), .glb_we_o(we_o[1]), .glb_bwe_o(bwe_o[1]),
        .glb_addr_o(addr_o[1]), .glb_wdata_o(wdata_o[1]),
        .ifmap_permit_push_matrix_o(ifp_o[1]), .ipsum_permit_push_matrix_o(ipp_o[1]),
        .opsum_permit_pop_matrix_o(opp_o[1]),
        .ifmap_glb_read_data_o(ifd_o[1]), .ipsum_glb_read_data_o(ipd_o[1]),
        .fifo_glb_busy_o(busy_o[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one record per instance. A transaction is tracked by its age in cycles since the
    // grant cycle: a read issues at age 1 and answers at age LAT+1, a write issues at age 1.
    int               m_ptr[2][3];   // class 0=ifmap 1=ipsum 2=opsum
    bit               m_act[2];
    int               m_age[2], m_cls[2], m_lane[2];
    logic [31:0]      m_addr[2], m_wdata[2];
    logic [3:0]       m_bwe[2];
    logic [LANES-1:0] m_mask[2][3];

    function automatic logic [LANES-1:0] req_of(input int c);
        if (c == 0) return if_req;
        if (c == 1) return ip_req;
        return op_req;
    endfunction

    function automatic logic [31:0] addr_of(input int c, input int l);
        if (c == 0) return if_addr[l*32 +: 32];
        if (c == 1) return ip_addr[l*32 +: 32];
        return op_addr[l*32 +: 32];
    endfunction

    task automatic model_compare(input int d);
        int               lat;
        bit               granted;
        int               lane;
        logic [LANES-1:0] r;
        logic             e_en, e_we, e_busy;
        logic [3:0]       e_bwe;
        logic [31:0]      e_addr, e_wdata, e_ifd, e_ipd;
        logic [LANES-1:0] e_p[3];
        lat = (d == 0) ? 1 : 3;
        e_en = 0; e_we = 0; e_busy = 0; e_bwe = 0;
        e_addr = 0; e_wdata = 0; e_ifd = 0; e_ipd = 0;
        for (int c = 0; c < 3; c++) e_p[c] = '0;

        if (rst) begin
            m_act[d] = 0;
            for (int c = 0; c < 3; c++) begin
                m_ptr[d][c]  = 0;
                m_mask[d][c] = '0;
            end
        end else begin
            if (!m_act[d]) begin
                granted = 0;
                for (int c = 2; c >= 0; c--) begin
                    r = req_of(c) & ~m_mask[d][c];
                    if (!granted && r != '0) begin
                        lane = -1;
                        for (int k = 0; k < LANES; k++)
                            if (lane < 0 && r[(m_ptr[d][c] + k) % LANES]) lane = (m_ptr[d][c] + k) % LANES;
                        granted     = 1;
                        m_act[d]    = 1;
                        m_age[d]    = 0;
                        m_cls[d]    = c;
                        m_lane[d]   = lane;
                        m_addr[d]   = addr_of(c, lane);
                        m_ptr[d][c] = (lane + 1) % LANES;
                        if (c == 2) begin
                            e_p[2][lane] = 1'b1;
                            e_busy       = 1;
                            m_wdata[d]   = op_data[lane*32 +: 32];
                            m_bwe[d]     = op_web[lane*4 +: 4];
                        end
                    end
                end
            end else begin
                e_busy = 1;
                if (m_cls[d] == 2) begin
                    e_en = 1; e_we = 1; e_bwe = m_bwe[d]; e_addr = m_addr[d]; e_wdata = m_wdata[d];
                    m_act[d] = 0;
                end else begin
                    if (m_age[d] == 1) begin
                        e_en = 1; e_addr = m_addr[d];
                    end
                    if (m_age[d] == lat + 1) begin
                        e_p[m_cls[d]][m_lane[d]] = 1'b1;
                        if (m_cls[d] == 0) e_ifd = glb_rdata;
                        else               e_ipd = glb_rdata;
                        m_act[d] = 0;
                    end
                end
            end
            m_age[d] = m_age[d] + 1;
            for (int c = 0; c < 3; c++) m_mask[d][c] = e_p[c];
        end

        check($sformatf("en%0d", d), en_o[d], e_en);
        check($sformatf("we%0d", d), we_o[d], e_we);
        check($sformatf("bwe%0d", d), bwe_o[d], e_bwe);
        check($sformatf("addr%0d", d), addr_o[d], e_addr);
        check($sformatf("wdata%0d", d), wdata_o[d], e_wdata);
        check($sformatf("if_permit%0d", d), ifp_o[d], e_p[0]);
        check($sformatf("ip_permit%0d", d), ipp_o[d], e_p[1]);
        check($sformatf("op_permit%0d", d), opp_o[d], e_p[2]);
        check($sformatf("if_data%0d", d), ifd_o[d], e_ifd);
        check($sformatf("ip_data%0d", d), ipd_o[d], e_ipd);
        check($sformatf("busy%0d", d), busy_o[d], e_busy);
        check($sformatf("onehot%0d", d), 32'($countones({ifp_o[d], ipp_o[d], opp_o[d]}) <= 1), 32'd1);
    endtask

    // Compare at the falling edge, then return just after the next rising edge for new stimulus.
    task automatic cycle();
        @(negedge clk);
        model_compare(0);
        model_compare(1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; if_req = '0; ip_req = '0; op_req = '0;
        if_addr = '0; ip_addr = '0; op_addr = '0; op_data = '0; op_web = '0; glb_rdata = '0;
        repeat (3) cycle();
        rst = 0; #1;
        check("rst_busy", busy_o[0], 0);
        check("rst_en", en_o[1], 0);
        repeat (2) cycle();

        // Single ifmap read, lane 5.
        if_addr[5*32 +: 32] = 32'h40; glb_rdata = 32'hDEADBEEF; if_req[5] = 1; #1;
        check("a_c0_busy", busy_o[0], 0);
        cycle();
        if_req = '0; #1;
        check("a_c1_en", en_o[0], 1);
        check("a_c1_we", we_o[0], 0);
        check("a_c1_addr", addr_o[0], 32'h40);
        check("a_c1_busy", busy_o[0], 1);
        check("a_c1_en_lat3", en_o[1], 1);
        cycle(); #1;
        check("a_c2_permit", ifp_o[0], 32'h20);
        check("a_c2_data", ifd_o[0], 32'hDEADBEEF);
        check("a_c2_busy", busy_o[0], 1);
        check("a_c2_permit_lat3", ifp_o[1], 32'h0);
        cycle(); cycle(); #1;
        check("a_c4_permit_lat3", ifp_o[1], 32'h20);
        check("a_c4_data_lat3", ifd_o[1], 32'hDEADBEEF);
        repeat (4) cycle();

        // Single opsum write, lane 3.
        op_addr[3*32 +: 32] = 32'h100; op_web[3*4 +: 4] = 4'hF; op_data[3*32 +: 32] = 32'h12345678;
        op_req[3] = 1; #1;
        check("b_c0_pop", opp_o[0], 32'h8);
        check("b_c0_busy", busy_o[0], 1);
        cycle();
        op_req = '0; #1;
        check("b_c1_en", en_o[0], 1);
        check("b_c1_we", we_o[0], 1);
        check("b_c1_addr", addr_o[0], 32'h100);
        check("b_c1_wdata", wdata_o[0], 32'h12345678);
        check("b_c1_bwe", bwe_o[0], 4'hF);
        check("b_c1_pop", opp_o[0], 32'h0);
        repeat (4) cycle();

        // All three classes on lane 0 in the same cycle.
        if_addr[31:0] = 32'h10; ip_addr[31:0] = 32'h20; op_addr[31:0] = 32'h30;
        op_data[31:0] = 32'h0000A5A5; op_web[3:0] = 4'h3; glb_rdata = 32'hCAFEF00D;
        if_req[0] = 1; ip_req[0] = 1; op_req[0] = 1; #1;
        check("c_c0_op", opp_o[0], 32'h1);
        check("c_c0_ip", ipp_o[0], 32'h0);
        cycle();
        op_req[0] = 0;
        cycle(); cycle(); cycle(); #1;
        check("c_c4_ip", ipp_o[0], 32'h1);
        cycle();
        ip_req[0] = 0;
        cycle(); cycle(); #1;
        check("c_c7_if", ifp_o[0], 32'h1);
        check("c_c7_ifdata", ifd_o[0], 32'hCAFEF00D);
        check("c_c7_ipdata", ipd_o[0], 32'h0);
        cycle();
        if_req[0] = 0;
        repeat (8) cycle();

        // Ipsum lanes 2, 7, 30 held: round-robin order 2, 7, 30, 2.
        ip_addr[2*32 +: 32] = 32'h200; ip_addr[7*32 +: 32] = 32'h700; ip_addr[30*32 +: 32] = 32'h3000;
        glb_rdata = 32'h0BADF00D;
        ip_req[2] = 1; ip_req[7] = 1; ip_req[30] = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c == 2)  check("d_rr0", ipp_o[0], 32'h0000_0004);
            if (c == 5)  check("d_rr1", ipp_o[0], 32'h0000_0080);
            if (c == 8)  check("d_rr2", ipp_o[0], 32'h4000_0000);
            if (c == 11) check("d_rr3", ipp_o[0], 32'h0000_0004);
            cycle();
        end
        ip_req = '0;
        repeat (12) cycle();

        // Single ifmap lane held: blinded for one cycle after its permit.
        if_addr[9*32 +: 32] = 32'h900; if_req[9] = 1;
        for (int c = 0; c < 7; c++) begin
            #1;
            if (c == 3) begin check("e_c3_en", en_o[0], 0); check("e_c3_busy", busy_o[0], 0); end
            if (c == 4) check("e_c4_en", en_o[0], 0);
            if (c == 5) check("e_c5_en", en_o[0], 1);
            if (c == 6) check("e_c6_permit", ifp_o[0], 32'h200);
            cycle();
        end
        if_req = '0;
        repeat (8) cycle();

        // Reset while the latency-3 instance sits in its wait phase.
        if_addr[1*32 +: 32] = 32'h44; if_req[1] = 1;
        cycle();
        if_req = '0;
        cycle();
        rst = 1;
        cycle();
        rst = 0; #1;
        check("f_c3_permit", ifp_o[1], 32'h0);
        check("f_c3_busy", busy_o[1], 0);
        check("f_c3_en", en_o[1], 0);
        cycle(); #1;
        check("f_c4_permit", ifp_o[1], 32'h0);
        repeat (4) cycle();

        // After reset the ifmap pointer restarts at lane 0.
        if_addr[31*32 +: 32] = 32'h31C; glb_rdata = 32'h77; if_req[1] = 1; if_req[31] = 1;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) if_req = '0;
            #1;
            if (c == 2) check("g_first", ifp_o[0], 32'h0000_0002);
            if (c == 5) check("g_second", ifp_o[0], 32'h8000_0000);
            cycle();
        end
        repeat (10) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
